// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 8-bit ALU: fetches register operands, drives the ALU,
// captures its registered result and flags, and writes back to an internal 8x8 register file.
module alu_sequencer #(
  parameter int REG_COUNT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        ld_valid,
  input  logic [2:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_fsl,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_mul_high,
  input  logic [3:0]  alu_sreg,
  output logic [3:0]  flags,
  output logic        done,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2,
    RETIRE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        load_s;
  logic        ready_s;
  logic [6:0]  instr_r;
  logic [7:0]  regs_r [REG_COUNT];
  logic [7:0]  alu_a_r;
  logic [7:0]  alu_b_r;
  logic [3:0]  alu_fsl_r;
  logic [7:0]  result_r;
  logic [7:0]  mul_high_r;
  logic [3:0]  flags_r;
  logic        done_r;
  logic        busy_r;
  logic [3:0]  op_s;
  logic [2:0]  rd_s;
  logic [2:0]  rd_hi_s;
  logic        unused_s;

  assign op_s     = instr_r[6:3];
  assign rd_s     = instr_r[2:0];
  assign rd_hi_s  = rd_s + 3'd1;
  assign unused_s = ^instr[2:0];

  // Next-state decode; a pending load in IDLE blocks instruction acceptance
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    load_s       = 1'b0;
    ready_s      = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = ~ld_valid;
        if (ld_valid) begin
          load_s = 1'b1;
        end else if (instr_valid) begin
          accept_s     = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC:    next_state_s = CAPTURE;
      CAPTURE: next_state_s = RETIRE;
      RETIRE:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register with registered done/busy derived from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      done_r  <= (next_state_s == RETIRE);
      busy_r  <= (next_state_s != IDLE);
    end
  end

  // Operand issue, result capture and flag capture
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r    <= 7'd0;
      alu_a_r    <= 8'h00;
      alu_b_r    <= 8'h00;
      alu_fsl_r  <= 4'h0;
      result_r   <= 8'h00;
      mul_high_r <= 8'h00;
      flags_r    <= 4'h0;
    end else begin
      // Operands are loaded on the accepting edge so they are already on the ALU during EXEC
      if (accept_s) begin
        instr_r   <= instr[15:9];
        alu_a_r   <= regs_r[instr[8:6]];
        alu_b_r   <= regs_r[instr[5:3]];
        alu_fsl_r <= instr[15:12];
      end
      if (state_r == CAPTURE) begin
        result_r   <= alu_result;
        mul_high_r <= alu_mul_high;
      end
      if (state_r == RETIRE) begin
        flags_r <= alu_sreg;
      end
    end
  end

  // Register file: direct loads in IDLE, writeback in RETIRE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (load_s) begin
      regs_r[ld_addr] <= ld_data;
    end else if (state_r == RETIRE) begin
      case (op_s)
        OP_MUL: begin
          regs_r[rd_s]    <= result_r;
          regs_r[rd_hi_s] <= mul_high_r;
        end
        OP_CMP: begin
          regs_r[rd_s] <= regs_r[rd_s];
        end
        default: begin
          regs_r[rd_s] <= result_r;
        end
      endcase
    end
  end

  assign instr_ready = ready_s;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_fsl     = alu_fsl_r;
  assign flags       = flags_r;
  assign done        = done_r;
  assign busy        = busy_r;
  assign dbg_data    = regs_r[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, register-file reference model,
// directed scenarios followed by randomized instruction/load traffic.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_fsl;
  logic [7:0]  alu_result;
  logic [7:0]  alu_mul_high;
  logic [3:0]  alu_sreg;
  logic [3:0]  flags;
  logic        done;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] ref_r [8];
  logic [3:0] ref_flags;
  logic       ref_c;

  alu_sequencer #(.REG_COUNT(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fsl(alu_fsl), .alu_result(alu_result),
    .alu_mul_high(alu_mul_high), .alu_sreg(alu_sreg), .flags(flags), .done(done),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #20 clk = ~clk;

  // ALU behaviour: returns {V,S,C,Z, high byte, low byte}
  function automatic logic [19:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op, input logic cin);
    logic [8:0]  s9;
    logic [15:0] p;
    logic [7:0]  r;
    logic [7:0]  h;
    logic        c, v, z, sf;
    s9 = 9'd0; p = 16'd0; r = 8'h00; h = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin s9 = {1'b0, a} + {1'b0, b}; r = s9[7:0]; c = s9[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h1, 4'hF: begin s9 = {1'b0, a} - {1'b0, b}; r = s9[7:0]; c = s9[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h2: begin s9 = {1'b0, a} + {1'b0, b} + {8'h00, cin}; r = s9[7:0]; c = s9[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h3: begin s9 = {1'b0, a} - {1'b0, b} - {8'h00, cin}; r = s9[7:0]; c = s9[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'h9: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'hA: begin r = {a[6:0], a[7]}; c = a[7]; end
      4'hB: begin r = {a[0], a[7:1]}; c = a[0]; end
      4'hC: begin s9 = {1'b0, a} + 9'd1; r = s9[7:0]; c = s9[8]; v = (r == 8'h80); end
      4'hD: begin s9 = {1'b0, a} - 9'd1; r = s9[7:0]; c = s9[8]; v = (r == 8'h7F); end
      4'hE: begin p = {8'h00, a} * {8'h00, b}; r = p[7:0]; h = p[15:8]; end
      default: r = a;
    endcase
    z  = (op == 4'hE) ? (p == 16'd0) : (r == 8'h00);
    sf = (op == 4'hE) ? p[15] : r[7];
    return {v, sf, c, z, h, r};
  endfunction

  // Harness ALU: registers the result one edge after operands appear, flags one edge later
  logic        busy_q;
  logic        pend_v;
  logic [3:0]  pend_f;
  logic [19:0] alu_out_s;
  assign alu_out_s = alu_eval(alu_a, alu_b, alu_fsl, alu_sreg[1]);

  always @(posedge clk) begin
    if (reset) begin
      alu_result <= 8'h00; alu_mul_high <= 8'h00; alu_sreg <= 4'h0;
      busy_q <= 1'b0; pend_v <= 1'b0; pend_f <= 4'h0;
    end else begin
      busy_q <= busy;
      if (busy && !busy_q) begin
        alu_result   <= alu_out_s[7:0];
        alu_mul_high <= alu_out_s[15:8];
        pend_f       <= alu_out_s[19:16];
        pend_v       <= 1'b1;
      end else if (pend_v) begin
        alu_sreg <= pend_f;
        pend_v   <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_R%0d", tag, i), {24'd0, dbg_data}, {24'd0, ref_r[i]});
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) ref_r[i] = 8'h00;
    ref_flags = 4'h0;
    ref_c     = 1'b0;
  endtask

  task automatic load(input logic [2:0] addr, input logic [7:0] data);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    step();
    ld_valid = 1'b0;
    ref_r[addr] = data;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2);
    logic [19:0] e;
    logic [2:0]  rd_hi;
    e = alu_eval(ref_r[rs1], ref_r[rs2], op, ref_c);
    rd_hi = rd + 3'd1;
    instr = {op, rd, rs1, rs2, 3'b000};
    instr_valid = 1'b1;
    #1;
    chk("accept_ready", {31'd0, instr_ready}, 32'd1);
    step();
    instr_valid = 1'b0;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_ready", {31'd0, instr_ready}, 32'd0);
    chk("exec_done", {31'd0, done}, 32'd0);
    chk("exec_alu_a", {24'd0, alu_a}, {24'd0, ref_r[rs1]});
    chk("exec_alu_b", {24'd0, alu_b}, {24'd0, ref_r[rs2]});
    chk("exec_alu_fsl", {28'd0, alu_fsl}, {28'd0, op});
    step();
    chk("capture_ready", {31'd0, instr_ready}, 32'd0);
    chk("capture_done", {31'd0, done}, 32'd0);
    step();
    chk("retire_ready", {31'd0, instr_ready}, 32'd0);
    chk("retire_done", {31'd0, done}, 32'd1);
    if (op == 4'hE) begin
      ref_r[rd]    = e[7:0];
      ref_r[rd_hi] = e[15:8];
    end else if (op != 4'hF) begin
      ref_r[rd] = e[7:0];
    end
    ref_flags = e[19:16];
    ref_c     = e[17];
    step();
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_flags", {28'd0, flags}, {28'd0, ref_flags});
    check_regs("wb");
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
    ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 8'h00; dbg_addr = 3'd0;
    ref_clear();
    step(); step(); step();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
    chk("rst_alu_fsl", {28'd0, alu_fsl}, 32'd0);
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    check_regs("rst");

    // ADD with signed overflow
    load(3'd1, 8'h70); load(3'd2, 8'h20);
    issue(4'h0, 3'd3, 3'd1, 3'd2);
    dbg_addr = 3'd3; #1;
    chk("add_R3", {24'd0, dbg_data}, 32'h90);
    chk("add_flags", {28'd0, flags}, 32'hC);

    // Multiply with rd=7 wrapping the high byte into R0
    load(3'd4, 8'h10); load(3'd5, 8'h10);
    issue(4'hE, 3'd7, 3'd4, 3'd5);
    dbg_addr = 3'd7; #1;
    chk("mul_R7", {24'd0, dbg_data}, 32'h00);
    dbg_addr = 3'd0; #1;
    chk("mul_R0", {24'd0, dbg_data}, 32'h01);
    chk("mul_S", {31'd0, flags[2]}, 32'd0);

    // Compare: flags only
    load(3'd1, 8'h05); load(3'd2, 8'h05);
    issue(4'hF, 3'd6, 3'd1, 3'd2);
    dbg_addr = 3'd6; #1;
    chk("cmp_R6", {24'd0, dbg_data}, 32'h00);
    chk("cmp_Z", {31'd0, flags[0]}, 32'd1);

    // Load and instruction offered together: load wins, instruction held
    ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 8'hAA;
    instr = {4'h0, 3'd1, 3'd2, 3'd0, 3'b000}; instr_valid = 1'b1;
    #1;
    chk("coll_ready", {31'd0, instr_ready}, 32'd0);
    step();
    ld_valid = 1'b0;
    ref_r[2] = 8'hAA;
    chk("coll_busy", {31'd0, busy}, 32'd0);
    dbg_addr = 3'd2; #1;
    chk("coll_R2", {24'd0, dbg_data}, 32'hAA);
    issue(4'h0, 3'd1, 3'd2, 3'd0);

    // Reset during CAPTURE abandons the instruction
    load(3'd1, 8'h11); load(3'd2, 8'h22);
    instr = {4'h0, 3'd3, 3'd1, 3'd2, 3'b000}; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ref_clear();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_flags", {28'd0, flags}, 32'd0);
    check_regs("midrst");
    step();
    chk("midrst_nodone", {31'd0, done}, 32'd0);

    // Carry chain: ADD sets C, ADDC consumes it
    load(3'd1, 8'hFF); load(3'd2, 8'h01);
    issue(4'h0, 3'd4, 3'd1, 3'd2);
    chk("b2b_C", {31'd0, flags[1]}, 32'd1);
    issue(4'h2, 3'd5, 3'd3, 3'd3);
    dbg_addr = 3'd5; #1;
    chk("b2b_addc", {24'd0, dbg_data}, 32'h01);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) load(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
